// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin share of one fifo enqueue port among NREQ valid/ready requesters, optional packet lock
module fifo_rr_arbiter #(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 8,
    parameter int PACKET = 1,
    localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  fifo_full,
    output logic                  fifo_enqueue,
    output logic [WIDTH-1:0]      fifo_data,
    output logic [IW-1:0]         grant_id,
    output logic                  busy
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state, next_state;
    logic [IW-1:0] last_id, lock_id, next_last, next_lock, winner;
    logic found, open, xfer;
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int k);
        int s;
        s = int'(a) + k;
        return IW'(s >= NREQ ? s - NREQ : s);
    endfunction
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            last_id <= IW'(NREQ - 1);
            lock_id <= '0;
        end else begin
            state   <= next_state;
            last_id <= next_last;
            lock_id <= next_lock;
        end
    end
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req_valid[wrap_add(last_id, k)]) begin
                found  = 1'b1;
                winner = wrap_add(last_id, k);
            end
        end
    end
    always_comb begin
        next_state = state;
        next_last  = last_id;
        next_lock  = lock_id;
        if (xfer && state == IDLE) begin
            next_last = winner;
            if (PACKET != 0 && !req_last[winner]) begin
                next_state = LOCKED;
                next_lock  = winner;
            end
        end else if (xfer && req_last[lock_id]) begin
            next_state = IDLE;
        end
    end
    always_comb begin
        grant_id     = (state == LOCKED) ? lock_id : winner;
        open         = !reset && !fifo_full && (state == LOCKED || found);
        xfer         = open && req_valid[grant_id];
        req_ready    = '0;
        req_ready[grant_id] = open;
        fifo_enqueue = xfer;
        fifo_data    = req_data[int'(grant_id)*WIDTH +: WIDTH];
        busy         = (state == LOCKED);
    end
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter: directed checks of round-robin order, packet lock, full stall and reset, NREQ=4 and NREQ=3
module tb_fifo_rr_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  valid, last, ready;
    logic [31:0] data;
    logic        full, enq, busy;
    logic [7:0]  fdata;
    logic [1:0]  grant;
    logic [2:0]  valid3, last3, ready3;
    logic [23:0] data3;
    logic        enq3, busy3;
    logic [7:0]  fdata3;
    logic [1:0]  grant3;
    int tests = 0;
    int fails = 0;
    int seq3 [4] = '{0, 1, 2, 0};
    always #5 clock = ~clock;
    fifo_rr_arbiter #(.NREQ(4), .WIDTH(8), .PACKET(1)) dut (
        .clock(clock), .reset(reset), .req_valid(valid), .req_last(last), .req_data(data),
        .req_ready(ready), .fifo_full(full), .fifo_enqueue(enq), .fifo_data(fdata),
        .grant_id(grant), .busy(busy)
    );
    fifo_rr_arbiter #(.NREQ(3), .WIDTH(8), .PACKET(0)) dut3 (
        .clock(clock), .reset(reset), .req_valid(valid3), .req_last(last3), .req_data(data3),
        .req_ready(ready3), .fifo_full(1'b0), .fifo_enqueue(enq3), .fifo_data(fdata3),
        .grant_id(grant3), .busy(busy3)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic nxt();
        @(posedge clock);
        #1;
    endtask
    task automatic expect_xfer(input string tag, input int g, input logic b);
        @(negedge clock);
        check({tag, "_enq"}, 32'(enq), 32'd1);
        check({tag, "_grant"}, 32'(grant), 32'(g));
        check({tag, "_ready"}, 32'(ready), 32'(1 << g));
        check({tag, "_data"}, 32'(fdata), 32'(data[g*8 +: 8]));
        check({tag, "_busy"}, 32'(busy), 32'(b));
        nxt();
    endtask
    initial begin
        reset = 1'b1; valid = '0; last = '0; full = 1'b0;
        data = 32'hA3A2A1A0; valid3 = '0; last3 = '0; data3 = 24'hB2B1B0;
        nxt();
        valid = 4'hF; last = 4'hF;
        @(negedge clock);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_enq", 32'(enq), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        nxt();
        reset = 1'b0;
        expect_xfer("rr0", 0, 1'b0);
        expect_xfer("rr1", 1, 1'b0);
        expect_xfer("rr2", 2, 1'b0);
        expect_xfer("rr3", 3, 1'b0);
        expect_xfer("rr4", 0, 1'b0);
        valid = 4'b0101;
        expect_xfer("alt0", 2, 1'b0);
        expect_xfer("alt1", 0, 1'b0);
        expect_xfer("alt2", 2, 1'b0);
        expect_xfer("alt3", 0, 1'b0);
        valid = 4'b0010;
        expect_xfer("pre1", 1, 1'b0);
        valid = 4'b0111; last = 4'b1011; data[23:16] = 8'hAA;
        expect_xfer("pkt_w1", 2, 1'b0);
        data[23:16] = 8'hBB;
        expect_xfer("pkt_w2", 2, 1'b1);
        data[23:16] = 8'hCC; last = 4'b1111;
        expect_xfer("pkt_w3", 2, 1'b1);
        expect_xfer("pkt_after", 0, 1'b0);
        valid = 4'b0011; last = 4'b1101;
        expect_xfer("lock1", 1, 1'b0);
        valid = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("gap_enq", 32'(enq), 32'd0);
            check("gap_ready", 32'(ready), 32'b0010);
            check("gap_busy", 32'(busy), 32'd1);
            nxt();
        end
        valid = 4'b0011; last = 4'hF;
        expect_xfer("lock_last", 1, 1'b1);
        expect_xfer("unlock", 0, 1'b0);
        valid = 4'hF; full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("full_enq", 32'(enq), 32'd0);
            check("full_ready", 32'(ready), 32'd0);
            nxt();
        end
        full = 1'b0;
        expect_xfer("full_resume", 1, 1'b0);
        last = 4'b1011;
        expect_xfer("rlock", 2, 1'b0);
        @(negedge clock);
        check("rlock_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("rmask_ready", 32'(ready), 32'd0);
        check("rmask_enq", 32'(enq), 32'd0);
        nxt();
        reset = 1'b0; valid3 = 3'b111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (i == 0) begin
                check("post_rst_busy", 32'(busy), 32'd0);
                check("post_rst_grant", 32'(grant), 32'd0);
                check("post_rst_enq", 32'(enq), 32'd1);
            end
            check("n3_grant", 32'(grant3), 32'(seq3[i]));
            check("n3_enq", 32'(enq3), 32'd1);
            check("n3_ready", 32'(ready3), 32'(1 << seq3[i]));
            check("n3_data", 32'(fdata3), 32'(data3[seq3[i]*8 +: 8]));
            check("n3_busy", 32'(busy3), 32'd0);
            nxt();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
